// File: rtl/ml_seq_pkg.sv
// Shared types and default frame geometry for the ML frame sequencer.
package ml_seq_pkg;

  typedef enum logic [2:0] {
    RECV      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2,
    SEND_RD   = 3'd3,
    SEND_HOLD = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_IN_WORDS  = 723;
  localparam int unsigned DEF_NUM_OUT_WORDS = 64;
  localparam int unsigned DEF_NUM_LAYERS    = 2;
  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_IN_ADDR_W     = 10;
  localparam int unsigned DEF_OUT_ADDR_W    = 6;

endpackage

// File: rtl/ml_frame_sequencer.sv
// Frame-level control of the ML stream coprocessor: receive a frame into the input RAM,
// run the MAC engine once per layer, then stream the result labels out with TLAST.
module ml_frame_sequencer
  import ml_seq_pkg::*;
#(
  parameter int unsigned NUM_IN_WORDS  = DEF_NUM_IN_WORDS,
  parameter int unsigned NUM_OUT_WORDS = DEF_NUM_OUT_WORDS,
  parameter int unsigned NUM_LAYERS    = DEF_NUM_LAYERS,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned IN_ADDR_W     = DEF_IN_ADDR_W,
  parameter int unsigned OUT_ADDR_W    = DEF_OUT_ADDR_W,
  localparam int unsigned LAYER_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  output logic                  S_AXIS_TREADY,
  input  logic [31:0]           S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  M_AXIS_TVALID,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  in_ram_we,
  output logic [IN_ADDR_W-1:0]  in_ram_addr,
  output logic [DATA_W-1:0]     in_ram_wdata,
  output logic                  eng_start,
  output logic [LAYER_W-1:0]    eng_layer,
  input  logic                  eng_done,
  output logic                  res_ram_rd,
  output logic [OUT_ADDR_W-1:0] res_ram_addr,
  input  logic [DATA_W-1:0]     res_ram_rdata,
  output logic                  busy,
  output logic                  tlast_err
);

  localparam logic [IN_ADDR_W-1:0]  IN_LAST    = IN_ADDR_W'(NUM_IN_WORDS - 1);
  localparam logic [OUT_ADDR_W-1:0] OUT_LAST   = OUT_ADDR_W'(NUM_OUT_WORDS - 1);
  localparam logic [LAYER_W-1:0]    LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_t                state;
  logic [IN_ADDR_W-1:0]  in_cnt;
  logic [OUT_ADDR_W-1:0] out_cnt;
  logic                  fresh;
  logic [DATA_W-1:0]     data_q;
  logic                  in_hs;
  logic                  in_last;
  logic                  out_hs;
  logic [DATA_W-1:0]     out_data;
  logic                  unused_tdata_hi;

  assign in_hs   = S_AXIS_TREADY & S_AXIS_TVALID;
  assign in_last = (in_cnt == IN_LAST);
  assign out_hs  = M_AXIS_TVALID & M_AXIS_TREADY;

  // Input RAM writes follow the handshake directly; TREADY is a register, so nothing leaks during reset.
  assign in_ram_we    = in_hs;
  assign in_ram_addr  = in_cnt;
  assign in_ram_wdata = in_hs ? S_AXIS_TDATA[DATA_W-1:0] : '0;

  // Result RAM data arrives in the first SEND_HOLD cycle; afterwards the captured copy is held.
  assign out_data     = fresh ? res_ram_rdata : data_q;
  assign M_AXIS_TDATA = 32'(out_data);

  assign unused_tdata_hi = ^S_AXIS_TDATA[31:DATA_W];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= RECV;
      in_cnt        <= '0;
      out_cnt       <= '0;
      S_AXIS_TREADY <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      eng_start     <= 1'b0;
      eng_layer     <= '0;
      res_ram_rd    <= 1'b0;
      res_ram_addr  <= '0;
      busy          <= 1'b0;
      tlast_err     <= 1'b0;
      fresh         <= 1'b0;
      data_q        <= '0;
    end else begin
      eng_start  <= 1'b0;
      res_ram_rd <= 1'b0;
      fresh      <= 1'b0;
      if (fresh) data_q <= res_ram_rdata;

      case (state)
        RECV: begin
          S_AXIS_TREADY <= 1'b1;
          if (in_hs) begin
            busy <= 1'b1;
            if (S_AXIS_TLAST != in_last) tlast_err <= 1'b1;
            if (in_last) begin
              in_cnt        <= '0;
              S_AXIS_TREADY <= 1'b0;
              eng_layer     <= '0;
              eng_start     <= 1'b1;
              state         <= START;
            end else begin
              in_cnt <= in_cnt + IN_ADDR_W'(1);
            end
          end
        end

        START: state <= WAIT;

        WAIT: begin
          if (eng_done) begin
            if (eng_layer == LAYER_LAST) begin
              out_cnt      <= '0;
              res_ram_rd   <= 1'b1;
              res_ram_addr <= '0;
              state        <= SEND_RD;
            end else begin
              eng_layer <= eng_layer + LAYER_W'(1);
              eng_start <= 1'b1;
              state     <= START;
            end
          end
        end

        SEND_RD: begin
          M_AXIS_TVALID <= 1'b1;
          M_AXIS_TLAST  <= (out_cnt == OUT_LAST);
          fresh         <= 1'b1;
          state         <= SEND_HOLD;
        end

        SEND_HOLD: begin
          if (out_hs) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            if (M_AXIS_TLAST) begin
              out_cnt       <= '0;
              busy          <= 1'b0;
              S_AXIS_TREADY <= 1'b1;
              state         <= RECV;
            end else begin
              out_cnt      <= out_cnt + OUT_ADDR_W'(1);
              res_ram_rd   <= 1'b1;
              res_ram_addr <= out_cnt + OUT_ADDR_W'(1);
              state        <= SEND_RD;
            end
          end
        end

        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_ml_frame_sequencer.sv
// Directed bench for ml_frame_sequencer with input RAM, result RAM and engine models.
module tb_ml_frame_sequencer;

  logic        ACLK;
  logic        ARESETN;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic        in_ram_we;
  logic [9:0]  in_ram_addr;
  logic [7:0]  in_ram_wdata;
  logic        eng_start;
  logic [0:0]  eng_layer;
  logic        eng_done;
  logic        res_ram_rd;
  logic [5:0]  res_ram_addr;
  logic [7:0]  res_ram_rdata;
  logic        busy;
  logic        tlast_err;

  int checks = 0;
  int errors = 0;

  ml_frame_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .in_ram_we(in_ram_we), .in_ram_addr(in_ram_addr), .in_ram_wdata(in_ram_wdata),
    .eng_start(eng_start), .eng_layer(eng_layer), .eng_done(eng_done),
    .res_ram_rd(res_ram_rd), .res_ram_addr(res_ram_addr), .res_ram_rdata(res_ram_rdata),
    .busy(busy), .tlast_err(tlast_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [64:0] outs;
  assign outs = {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, in_ram_we,
                 in_ram_addr, in_ram_wdata, eng_start, eng_layer, res_ram_rd, res_ram_addr,
                 busy, tlast_err};

  // Result RAM model: one-cycle read latency, mem[i] = i ^ 0x5A.
  always @(posedge ACLK)
    if (res_ram_rd) res_ram_rdata <= 8'(res_ram_addr) ^ 8'h5A;

  // Engine model: eng_done pulses 10 cycles after eng_start.
  int eng_cnt;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) eng_cnt <= 9;
      else if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_cnt  <= 0;
      end else if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
    end
  end

  // Output ready pattern: always ready, or 1-0-0 when tr_mode is set.
  logic tr_mode = 1'b0;
  int   tr_pat  = 0;
  always @(negedge ACLK) begin
    M_AXIS_TREADY = tr_mode ? (tr_pat == 0) : 1'b1;
    tr_pat = (tr_pat == 2) ? 0 : tr_pat + 1;
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Monitors: cumulative tallies and error counts that the test tasks inspect.
  int wr_idx, out_idx, lay_exp;
  int wr_tot = 0, wr_bad = 0, out_tot = 0, out_bad = 0, tl_tot = 0;
  int eng_starts = 0, eng_bad = 0, stall_bad = 0;
  int last_in_cyc = 0, start0_cyc = 0, done1_cyc = 0, first_tv_cyc = 0;
  int tlast_cyc = 0, b2b_gap = 0;
  logic stall_prev, tv_prev, es_prev, tl_prev;
  logic [31:0] d_prev;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_idx     <= 0;
      out_idx    <= 0;
      lay_exp    <= 0;
      stall_prev <= 1'b0;
      tv_prev    <= 1'b0;
      es_prev    <= 1'b0;
    end else begin
      if (in_ram_we) begin
        if (in_ram_addr !== 10'(wr_idx) || in_ram_wdata !== 8'(wr_idx)) wr_bad <= wr_bad + 1;
        wr_tot <= wr_tot + 1;
        wr_idx <= (wr_idx == 722) ? 0 : wr_idx + 1;
        if (wr_idx == 722) last_in_cyc <= cyc;
        if (wr_idx == 0) b2b_gap <= cyc - tlast_cyc;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (M_AXIS_TDATA !== 32'(8'(out_idx) ^ 8'h5A) || M_AXIS_TLAST !== (out_idx == 63))
          out_bad <= out_bad + 1;
        out_tot <= out_tot + 1;
        out_idx <= (out_idx == 63) ? 0 : out_idx + 1;
        if (M_AXIS_TLAST) begin
          tl_tot    <= tl_tot + 1;
          tlast_cyc <= cyc;
        end
      end
      if (M_AXIS_TVALID && !tv_prev && out_idx == 0) first_tv_cyc <= cyc;
      if (stall_prev && (!M_AXIS_TVALID || M_AXIS_TDATA !== d_prev || M_AXIS_TLAST !== tl_prev))
        stall_bad <= stall_bad + 1;
      stall_prev <= M_AXIS_TVALID & ~M_AXIS_TREADY;
      d_prev     <= M_AXIS_TDATA;
      tl_prev    <= M_AXIS_TLAST;
      tv_prev    <= M_AXIS_TVALID;
      if (eng_start) begin
        if (eng_layer !== 1'(lay_exp) || es_prev) eng_bad <= eng_bad + 1;
        eng_starts <= eng_starts + 1;
        lay_exp    <= (lay_exp + 1) % 2;
        if (eng_layer == 1'b0) start0_cyc <= cyc;
      end
      es_prev <= eng_start;
      if (eng_done && eng_layer == 1'b1) done1_cyc <= cyc;
    end
  end

  task automatic run_frame(input int gap, input int tl_mode);
    int i = 0;
    int n = 0;
    while (i < 723 && n < 20000) begin
      @(negedge ACLK);
      n++;
      if (gap != 0 && (n % 3) == 0) S_AXIS_TVALID = 1'b0;
      else begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'hABCD_0000 | 32'(i);
        S_AXIS_TLAST  = (tl_mode == 0) ? (i == 722) :
                        (tl_mode == 2) ? (i == 100 || i == 722) : 1'b0;
        if (S_AXIS_TREADY) i++;
      end
    end
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    checks++;
    if (i != 723) begin
      errors++;
      $display("FAIL input_accept: accepted %0d words, expected 723", i);
    end
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (out_tot < target && n < 20000) begin
      @(negedge ACLK);
      n++;
    end
    repeat (2) @(negedge ACLK);
    checks++;
    if (out_tot != target) begin
      errors++;
      $display("FAIL output_count: got %0d transfers, expected %0d", out_tot, target);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TDATA  = 32'h0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (outs !== 65'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({S_AXIS_TREADY, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: tready/busy %b, expected 10", {S_AXIS_TREADY, busy});
    end
  endtask

  task automatic test_single_frame();
    int w0 = wr_tot, wb0 = wr_bad, s0 = eng_starts, eb0 = eng_bad;
    int o0 = out_tot, ob0 = out_bad, t0 = tl_tot;
    run_frame(0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b, expected 1", busy); end
    wait_out(o0 + 64);
    checks++;
    if (wr_tot - w0 != 723 || wr_bad != wb0) begin
      errors++;
      $display("FAIL single_writes: %0d writes, %0d bad, expected 723/0", wr_tot - w0, wr_bad - wb0);
    end
    checks++;
    if (eng_starts - s0 != 2 || eng_bad != eb0) begin
      errors++;
      $display("FAIL single_engine: %0d starts, %0d bad, expected 2/0", eng_starts - s0, eng_bad - eb0);
    end
    checks++;
    if (out_bad != ob0 || tl_tot - t0 != 1) begin
      errors++;
      $display("FAIL single_outputs: %0d bad, %0d tlast, expected 0/1", out_bad - ob0, tl_tot - t0);
    end
    checks++;
    if (start0_cyc - last_in_cyc != 1) begin
      errors++;
      $display("FAIL start_latency: got %0d, expected 1", start0_cyc - last_in_cyc);
    end
    checks++;
    if (first_tv_cyc - done1_cyc != 2) begin
      errors++;
      $display("FAIL tvalid_latency: got %0d, expected 2", first_tv_cyc - done1_cyc);
    end
    checks++;
    if ({busy, tlast_err, S_AXIS_TREADY} !== 3'b001) begin
      errors++;
      $display("FAIL single_idle: busy/err/tready %b, expected 001", {busy, tlast_err, S_AXIS_TREADY});
    end
  endtask

  task automatic test_gaps();
    int w0 = wr_tot, wb0 = wr_bad, o0 = out_tot, ob0 = out_bad;
    run_frame(1, 0);
    wait_out(o0 + 64);
    checks++;
    if (wr_tot - w0 != 723 || wr_bad != wb0 || out_bad != ob0) begin
      errors++;
      $display("FAIL gap_frame: %0d writes, %0d wbad, %0d obad, expected 723/0/0",
               wr_tot - w0, wr_bad - wb0, out_bad - ob0);
    end
  endtask

  task automatic test_stall();
    int o0 = out_tot, ob0 = out_bad, sb0 = stall_bad;
    tr_mode = 1'b1;
    run_frame(0, 0);
    wait_out(o0 + 64);
    tr_mode = 1'b0;
    checks++;
    if (stall_bad != sb0 || out_bad != ob0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable, %0d bad, expected 0/0", stall_bad - sb0, out_bad - ob0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: busy %b, expected 0", busy); end
  endtask

  task automatic test_tlast();
    int o0 = out_tot;
    run_frame(0, 1);
    wait_out(o0 + 64);
    checks++;
    if (tlast_err !== 1'b1) begin errors++; $display("FAIL tlast_missing: err %b, expected 1", tlast_err); end
    do_reset();
    checks++;
    if (tlast_err !== 1'b0) begin errors++; $display("FAIL tlast_clear: err %b, expected 0", tlast_err); end
    o0 = out_tot;
    run_frame(0, 2);
    wait_out(o0 + 64);
    checks++;
    if (tlast_err !== 1'b1) begin errors++; $display("FAIL tlast_early: err %b, expected 1", tlast_err); end
    do_reset();
  endtask

  task automatic test_abort();
    int s0 = eng_starts, o0 = out_tot, n = 0;
    int w0, wb0, ob0;
    run_frame(0, 0);
    while (eng_starts - s0 < 2 && n < 2000) begin
      @(negedge ACLK);
      n++;
    end
    repeat (3) @(negedge ACLK);
    checks++;
    if ({busy, eng_layer, M_AXIS_TVALID} !== 3'b110) begin
      errors++;
      $display("FAIL abort_wait: busy/layer/tvalid %b, expected 110", {busy, eng_layer, M_AXIS_TVALID});
    end
    ARESETN = 1'b0;
    #1;
    checks++;
    if (outs !== 65'h0) begin errors++; $display("FAIL abort_outputs: got %h, expected 0", outs); end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    w0 = wr_tot; wb0 = wr_bad; ob0 = out_bad;
    run_frame(0, 0);
    wait_out(o0 + 64);
    checks++;
    if (wr_tot - w0 != 723 || wr_bad != wb0 || out_bad != ob0) begin
      errors++;
      $display("FAIL abort_restart: %0d writes, %0d wbad, %0d obad, expected 723/0/0",
               wr_tot - w0, wr_bad - wb0, out_bad - ob0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_tot, wb0 = wr_bad, o0 = out_tot, ob0 = out_bad, t0 = tl_tot;
    run_frame(0, 0);
    run_frame(0, 0);
    wait_out(o0 + 128);
    checks++;
    if (wr_tot - w0 != 1446 || wr_bad != wb0) begin
      errors++;
      $display("FAIL b2b_writes: %0d writes, %0d bad, expected 1446/0", wr_tot - w0, wr_bad - wb0);
    end
    checks++;
    if (out_bad != ob0 || tl_tot - t0 != 2) begin
      errors++;
      $display("FAIL b2b_outputs: %0d bad, %0d tlast, expected 0/2", out_bad - ob0, tl_tot - t0);
    end
    checks++;
    if (b2b_gap != 1) begin
      errors++;
      $display("FAIL b2b_gap: second frame began %0d cycles after TLAST, expected 1", b2b_gap);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_stall();
    test_tlast();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
